multicycle_subtractor: RTL
==========================

# multicycle_subtractor

Chunked multi-cycle subtractor for the ALU. It computes `diff = a - b - b_in` over `WIDTH` bits, processing `CHUNK` bits per clock and carrying the borrow between chunks in a register. This complements the ripple-carry adder chain, which only adds. It replaces a full-width combinational borrow chain with a short per-cycle chain, and uses valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 64: operand and result width; must be a multiple of `CHUNK`.
- `CHUNK`, 16: bits processed per cycle. `N = WIDTH/CHUNK` cycles per operation (default 4).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands. Equals `(state==IDLE) && !rst`.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `b_in` input 1: borrow in.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: `(a - b - b_in) mod 2^WIDTH`.
- `b_out` output 1: borrow out. 1 iff unsigned `a < b + b_in`.
- `ovf` output 1: 1 iff the signed result `a - b - b_in` lies outside `[-2^(WIDTH-1), 2^(WIDTH-1)-1]`.
- `zero` output 1: 1 iff `diff == 0`.

## Operation
- Arithmetic: each chunk computes `a_k + ~b_k + c`, where `c` is the carry register. `c` is initialised to `~b_in` on accept. After each chunk, `c` takes that chunk's carry out. `b_out = ~c_final`.
- `ovf` = carry into bit `WIDTH-1` XOR carry out of bit `WIDTH-1`.
- `zero` is evaluated on the full registered `diff`.
- States:
  - IDLE: `in_ready=1`. On `in_valid`, register `a`, `b`, `b_in`; set `count=0`; go to RUN.
  - RUN: each cycle, write `diff[count*CHUNK +: CHUNK]` and update `c`. When `count==N-1`, register `b_out`, `ovf` and `zero`, then go to DONE. Otherwise increment `count`.
  - DONE: `out_valid=1`. All outputs are held stable until `out_ready=1`, then go to IDLE.
- No overlap between operations. `in_ready=0` in RUN and DONE, and `in_valid` is ignored in those states.
- `diff`, `b_out`, `ovf` and `zero` retain their values after the result handshake until the next operation starts overwriting them. They are only meaningful while `out_valid=1`.
- Operand registers are stable throughout RUN, so input changes after accept have no effect.
- Reset (asynchronous, any state, including mid-RUN): state goes to IDLE. `count`, `c`, `diff`, `b_out`, `ovf`, `zero` and `out_valid` all go to 0. The partial result is discarded. `in_ready=0` while `rst=1` and returns to 1 on the first cycle after deassert.

## Timing
- Accept at rising edge T (`in_valid && in_ready`). The chunks are computed on edges T+1 through T+N. `out_valid` rises after edge T+N, giving a latency of N cycles (4 at defaults).
- Result handshake at edge R (`out_valid && out_ready`). The block is in IDLE after R and can accept new operands at edge R+1 at the earliest.
- Peak throughput is one operation per N+2 cycles.
- Reset values: `in_ready=1` (once `rst=0`), `out_valid=0`, `diff=0`, `b_out=0`, `ovf=0`, `zero=0`.
- `out_valid` and the result outputs are registered. `in_ready` is decoded from the state register only, with no combinational path from `out_ready`.

## Test plan
- Basic: `a=5`, `b=3`, `b_in=0`, `out_ready=1` → `diff=2`, `b_out=0`, `ovf=0`, `zero=0`. `out_valid` rises exactly 4 cycles after accept and falls 1 cycle later.
- Underflow: `a=0`, `b=1` → `diff=0xFFFF_FFFF_FFFF_FFFF`, `b_out=1`, `ovf=0`.
- Borrow across chunks:
  - `a=0x0000_0000_0001_0000`, `b=1` → `diff=0x0000_0000_0000_FFFF`, `b_out=0`.
  - `a=b=0x1234`, `b_in=1` → `diff` all ones, `b_out=1`.
  - `a=b=0x1234`, `b_in=0` → `zero=1`.
- Signed overflow: `a=0x8000_0000_0000_0000`, `b=1` → `diff=0x7FFF_FFFF_FFFF_FFFF`, `ovf=1`, `b_out=0`.
  - `a=0x7FFF_FFFF_FFFF_FFFF`, `b=0xFFFF_FFFF_FFFF_FFFF` → `ovf=1`.
- Backpressure: hold `out_ready=0` for 3 cycles after `out_valid` → `out_valid`, `diff` and flags stay stable, `in_ready=0`, and `in_valid` pulses with new operands are ignored. Raising `out_ready` completes the handshake, and the next operation gives a correct result.
- Reset mid-RUN: assert `rst` during chunk 2 → `out_valid=0`, `diff=0`, flags 0 immediately. After deassert `in_ready=1`, and the following operation with `a=10`, `b=4` gives `diff=6` with 4-cycle latency.

Source files
------------

// File: rtl/multicycle_subtractor.sv
// multicycle_subtractor
//   Chunked multi-cycle subtractor: diff = (a - b - b_in) mod 2^WIDTH.
//   Each RUN cycle handles CHUNK bits as a_k + ~b_k + c. The carry register c
//   starts at ~b_in and is carried from one chunk to the next.
//   A result takes N = WIDTH/CHUNK cycles. Only one operation is in flight.
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready only in IDLE, low in reset)
//   a, b, b_in        : minuend, subtrahend, borrow in
//   out_valid/out_ready: result handshake; results are held until accepted
//   diff, b_out, ovf, zero : registered result and flags
module multicycle_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] a_k_s;
  logic [CHUNK-1:0] nb_k_s;
  logic [CHUNK:0]   chunk_sum_s;
  logic             carry_into_msb_s;

  // Current chunk: a_k + ~b_k + c, with the carry out in the top bit.
  always_comb begin
    a_k_s       = a_q[count_q*CHUNK +: CHUNK];
    nb_k_s      = ~b_q[count_q*CHUNK +: CHUNK];
    chunk_sum_s = {1'b0, a_k_s} + {1'b0, nb_k_s} + {{CHUNK{1'b0}}, c_q};
    // The carry into the top bit is recovered from its sum bit. It only matters
    // on the last chunk, where the top chunk bit is bit WIDTH-1.
    carry_into_msb_s = a_k_s[CHUNK-1] ^ nb_k_s[CHUNK-1] ^ chunk_sum_s[CHUNK-1];
  end

  // Next-state logic and datapath updates for IDLE -> RUN -> DONE.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    diff_d      = diff_q;
    b_out_d     = b_out_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          c_d     = ~b_in;
          count_d = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        diff_d[count_q*CHUNK +: CHUNK] = chunk_sum_s[CHUNK-1:0];
        c_d = chunk_sum_s[CHUNK];
        if (count_q == LAST) begin
          b_out_d     = ~chunk_sum_s[CHUNK];
          ovf_d       = carry_into_msb_s ^ chunk_sum_s[CHUNK];
          zero_d      = (diff_d == {WIDTH{1'b0}});
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, operand and result registers. Reset drops any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= {CW{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      c_q         <= 1'b0;
      diff_q      <= {WIDTH{1'b0}};
      b_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      diff_q      <= diff_d;
      b_out_q     <= b_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
